// File: rtl/fir_result_stream_if.sv
// fir_result_stream_if: result stream and status bundle between the FIR output stage and the host writer
interface fir_result_stream_if #(
  parameter int FLOAT_W = 32,
  parameter int DEPTH = 8
);
  logic in_en;
  logic [FLOAT_W-1:0] in_data;
  logic [FLOAT_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic overflow;
  logic running;
  modport master (
    output in_en, in_data, out_ready,
    input out_data, out_valid, level, overflow, running
  );
  modport slave (
    input in_en, in_data, out_ready,
    output out_data, out_valid, level, overflow, running
  );
endinterface

// File: rtl/fir_result_stream.sv
// fir_result_stream: decimates FIR results by OSR, skips SKIP warm-up results, buffers the rest in a FWFT FIFO
module fir_result_stream #(
  parameter int OSR = 1,
  parameter int FLOAT_W = 32,
  parameter int DEPTH = 8,
  parameter int SKIP = 0
) (
  input logic clk,
  input logic rst,
  fir_result_stream_if.slave s
);
  localparam int PW = OSR > 1 ? $clog2(OSR) : 1;
  localparam int SW = SKIP > 0 ? $clog2(SKIP + 1) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  typedef enum logic {WARMUP, RUN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic overflow_q, overflow_d;
  logic [FLOAT_W-1:0] mem_q [DEPTH];
  logic take, pop, push, full, wr, valid, warm_take;
  always_comb begin
    valid = level_q != '0;
    take = s.in_en && phase_q == '0;
    pop = valid && s.out_ready;
    push = take && state_q == RUN;
    full = level_q == LW'(DEPTH);
    wr = push && (!full || pop);
    warm_take = take && state_q == WARMUP;
    phase_d = s.in_en ? (phase_q == PW'(OSR - 1) ? '0 : phase_q + 1'b1) : phase_q;
    skip_d = warm_take ? skip_q + 1'b1 : skip_q;
    state_d = warm_take && skip_q == SW'(SKIP - 1) ? RUN : state_q;
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d = wr && !pop ? level_q + 1'b1 : (pop && !wr ? level_q - 1'b1 : level_q);
    overflow_d = overflow_q || (push && full && !pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SKIP == 0 ? RUN : WARMUP;
      phase_q <= '0;
      skip_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      skip_q <= skip_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= s.in_data;
  end
  assign s.out_valid = valid;
  assign s.out_data = valid ? mem_q[rd_ptr_q] : '0;
  assign s.level = level_q;
  assign s.overflow = overflow_q;
  assign s.running = state_q == RUN;
endmodule

// File: tb/tb_fir_result_stream.sv
// tb_fir_result_stream: three parameterisations driven together and checked every cycle against a queue model
module tb_fir_result_stream;
  localparam int N = 3;
  logic clk, rst, in_en, out_ready;
  logic [31:0] in_data;
  int checks = 0;
  int errors = 0;
  int c_osr [N] = '{1, 4, 2};
  int c_skip [N] = '{0, 0, 3};
  int c_dep [N] = '{8, 8, 4};
  int ph [N];
  int sk [N];
  bit run [N];
  bit ov [N];
  logic [31:0] mq [N][$];
  logic [31:0] got [N][$];
  logic [31:0] d_data [N];
  logic d_valid [N];
  logic d_ov [N];
  logic d_run [N];
  int d_level [N];
  fir_result_stream_if #(.FLOAT_W(32), .DEPTH(8)) b0 ();
  fir_result_stream_if #(.FLOAT_W(32), .DEPTH(8)) b1 ();
  fir_result_stream_if #(.FLOAT_W(32), .DEPTH(4)) b2 ();
  fir_result_stream #(.OSR(1), .FLOAT_W(32), .DEPTH(8), .SKIP(0)) u0 (.clk(clk), .rst(rst), .s(b0));
  fir_result_stream #(.OSR(4), .FLOAT_W(32), .DEPTH(8), .SKIP(0)) u1 (.clk(clk), .rst(rst), .s(b1));
  fir_result_stream #(.OSR(2), .FLOAT_W(32), .DEPTH(4), .SKIP(3)) u2 (.clk(clk), .rst(rst), .s(b2));
  assign b0.in_en = in_en;
  assign b0.in_data = in_data;
  assign b0.out_ready = out_ready;
  assign b1.in_en = in_en;
  assign b1.in_data = in_data;
  assign b1.out_ready = out_ready;
  assign b2.in_en = in_en;
  assign b2.in_data = in_data;
  assign b2.out_ready = out_ready;
  always_comb begin
    d_data[0] = b0.out_data;
    d_valid[0] = b0.out_valid;
    d_level[0] = int'(b0.level);
    d_ov[0] = b0.overflow;
    d_run[0] = b0.running;
    d_data[1] = b1.out_data;
    d_valid[1] = b1.out_valid;
    d_level[1] = int'(b1.level);
    d_ov[1] = b1.overflow;
    d_run[1] = b1.running;
    d_data[2] = b2.out_data;
    d_valid[2] = b2.out_valid;
    d_level[2] = int'(b2.level);
    d_ov[2] = b2.overflow;
    d_run[2] = b2.running;
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i] = 0;
      sk[i] = 0;
      run[i] = c_skip[i] == 0;
      ov[i] = 1'b0;
      mq[i].delete();
    end
  endtask
  task automatic model_step(int i);
    bit take, pop, push;
    take = in_en && ph[i] == 0;
    pop = mq[i].size() > 0 && out_ready;
    push = take && run[i];
    if (take && !run[i]) begin
      sk[i]++;
      if (sk[i] == c_skip[i]) run[i] = 1'b1;
    end
    if (pop) got[i].push_back(mq[i].pop_front());
    if (push) begin
      if (mq[i].size() < c_dep[i]) mq[i].push_back(in_data);
      else ov[i] = 1'b1;
    end
    if (in_en) ph[i] = (ph[i] + 1) % c_osr[i];
  endtask
  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("d%0d.out_valid", i), d_valid[i], mq[i].size() > 0);
      chk($sformatf("d%0d.level", i), d_level[i], mq[i].size());
      chk($sformatf("d%0d.overflow", i), d_ov[i], ov[i]);
      chk($sformatf("d%0d.running", i), d_run[i], run[i]);
      if (mq[i].size() > 0) chk($sformatf("d%0d.out_data", i), d_data[i], mq[i][0]);
    end
  endtask
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else for (int i = 0; i < N; i++) model_step(i);
      #1;
      compare_all();
    end
  end
  task automatic cyc(bit en, logic [31:0] d, bit rdy);
    in_en = en;
    in_data = d;
    out_ready = rdy;
    @(negedge clk);
  endtask
  task automatic do_reset();
    in_en = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) got[i].delete();
  endtask
  task automatic chk_stream(string name, int i, int base, int step, int n);
    chk($sformatf("%s.count", name), got[i].size(), n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s[%0d]", name, k), k < got[i].size() ? longint'(got[i][k]) : -1, base + k * step);
  endtask
  initial begin
    rst = 1'b1;
    in_en = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("reset.level0", d_level[0], 0);
    chk("reset.valid0", d_valid[0], 0);
    chk("reset.data0", d_data[0], 0);
    chk("reset.running0", d_run[0], 1);
    chk("reset.running2", d_run[2], 0);
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, k, 1'b1);
      if (k == 2) repeat (3) cyc(1'b0, 32'hdead_0000 + k, 1'b1);
    end
    repeat (4) cyc(1'b0, 0, 1'b1);
    chk_stream("p1.osr1", 0, 0, 1, 16);
    chk_stream("p1.osr4", 1, 0, 4, 4);
    chk_stream("p1.skip3", 2, 6, 2, 5);
    do_reset();
    for (int k = 0; k < 9; k++) cyc(1'b1, 100 + k, 1'b0);
    chk("p2.level0", d_level[0], 8);
    chk("p2.overflow0", d_ov[0], 1);
    chk("p2.level1", d_level[1], 3);
    chk("p2.level2", d_level[2], 2);
    repeat (10) cyc(1'b0, 0, 1'b1);
    chk_stream("p2.drain", 0, 100, 1, 8);
    chk("p2.sticky", d_ov[0], 1);
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 200 + k, 1'b0);
    chk("p3.full", d_level[0], 8);
    cyc(1'b1, 208, 1'b1);
    chk("p3.level", d_level[0], 8);
    chk("p3.overflow", d_ov[0], 0);
    repeat (10) cyc(1'b0, 0, 1'b1);
    chk_stream("p3.order", 0, 200, 1, 9);
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, 300 + k, 1'b0);
    chk("p4.level", d_level[0], 5);
    #2 rst = 1'b1;
    #1;
    chk("p4.async_level", d_level[0], 0);
    chk("p4.async_valid", d_valid[0], 0);
    chk("p4.async_ovf1", d_ov[1], 0);
    chk("p4.async_run2", d_run[2], 0);
    #4 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) got[i].delete();
    for (int k = 0; k < 12; k++) cyc(1'b1, 400 + k, 1'b1);
    repeat (6) cyc(1'b0, 0, 1'b1);
    chk_stream("p4.osr1", 0, 400, 1, 12);
    chk_stream("p4.osr4", 1, 400, 4, 3);
    chk_stream("p4.skip3", 2, 406, 2, 3);
    do_reset();
    for (int b = 0; b < 12; b++) begin
      int pr;
      pr = $urandom_range(0, 4);
      for (int k = 0; k < 250; k++) begin
        in_en = $urandom_range(0, 3) != 0;
        in_data = $urandom;
        out_ready = $urandom_range(0, 3) < pr;
        if ($urandom_range(0, 399) == 0) begin
          #2 rst = 1'b1;
          #4 rst = 1'b0;
        end
        @(negedge clk);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
